// File: rtl/accum_window_if.sv
// ============================================================================
//  Module   : accum_window_if
//  Brief    : Sample/sum bundle between a sample source and accum_window.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface accum_window_if #(
    parameter int IW = 16,
    parameter int DW = 32,
    parameter int CW = 10
);
    logic                 i_Clr;
    logic                 i_Data_vld;
    logic signed [IW-1:0] i_Data;
    logic                 o_Sum_vld;
    logic signed [DW-1:0] o_Sum;
    logic [CW-1:0]        o_Cnt;
    logic                 o_Ovf;

    modport master (
        output i_Clr, i_Data_vld, i_Data,
        input  o_Sum_vld, o_Sum, o_Cnt, o_Ovf
    );

    modport slave (
        input  i_Clr, i_Data_vld, i_Data,
        output o_Sum_vld, o_Sum, o_Cnt, o_Ovf
    );
endinterface

`default_nettype wire

// File: rtl/accum_window.sv
// ============================================================================
//  Module   : accum_window
//  Brief    : Signed accumulator summing NUM valid samples per window; emits the
//             window sum with a one-cycle pulse. Define ACC_SAT_EN for
//             saturating adds with a sticky per-window overflow flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module accum_window #(
    parameter int IW  = 16,
    parameter int DW  = 32,
    parameter int NUM = 1024
) (
    input  wire logic        i_Sys_clk,
    input  wire logic        i_Rst,
    accum_window_if.slave    bus
);
    localparam int             CW     = $clog2(NUM);
    localparam logic [CW-1:0]  c_LAST = CW'(NUM - 1);

    logic signed [DW-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic signed [DW-1:0] r_sum;
    logic                 r_sum_vld;

    logic signed [DW-1:0] w_sext;
    logic signed [DW-1:0] w_base_acc;
    logic [CW-1:0]        w_base_cnt;
    logic signed [DW-1:0] w_add;
    logic signed [DW-1:0] w_res;
    logic                 w_last;

    // A clear with a valid sample restarts the window from that sample.
    assign w_sext     = {{(DW-IW){bus.i_Data[IW-1]}}, bus.i_Data};
    assign w_base_acc = bus.i_Clr ? '0 : r_acc;
    assign w_base_cnt = bus.i_Clr ? '0 : r_cnt;
    assign w_add      = w_base_acc + w_sext;
    assign w_last     = (w_base_cnt == c_LAST);

`ifdef ACC_SAT_EN
    localparam logic signed [DW-1:0] c_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] c_MIN = {1'b1, {(DW-1){1'b0}}};

    logic r_ovf;
    logic r_ovf_out;
    logic w_ov;
    logic w_ovf_next;

    assign w_ov       = (w_base_acc[DW-1] == w_sext[DW-1]) && (w_add[DW-1] != w_base_acc[DW-1]);
    assign w_res      = w_ov ? (w_base_acc[DW-1] ? c_MIN : c_MAX) : w_add;
    assign w_ovf_next = (r_ovf && !bus.i_Clr) || w_ov;

    always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_ovf     <= 1'b0;
            r_ovf_out <= 1'b0;
        end else if (bus.i_Data_vld) begin
            if (w_last) begin
                r_ovf     <= 1'b0;
                r_ovf_out <= w_ovf_next;
            end else begin
                r_ovf     <= w_ovf_next;
            end
        end else if (bus.i_Clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.o_Ovf = r_ovf_out;
`else
    assign w_res     = w_add;
    assign bus.o_Ovf = 1'b0;
`endif

    always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_sum_vld <= 1'b0;
        end else begin
            r_sum_vld <= 1'b0;
            if (bus.i_Data_vld) begin
                if (w_last) begin
                    r_sum     <= w_res;
                    r_sum_vld <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc     <= w_res;
                    r_cnt     <= w_base_cnt + CW'(1);
                end
            end else if (bus.i_Clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
        end
    end

    assign bus.o_Sum     = r_sum;
    assign bus.o_Sum_vld = r_sum_vld;
    assign bus.o_Cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_accum_window.sv
// ============================================================================
//  Module   : tb_accum_window
//  Brief    : Randomized bench for accum_window with a queue-based window model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_accum_window;
    localparam int IW  = 16;
    localparam int DW  = 17;
    localparam int NUM = 4;
    localparam int CW  = 2;
    localparam longint MODV = longint'(1) <<< DW;
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;

    always #5 clk = ~clk;

    accum_window_if #(.IW(IW), .DW(DW), .CW(CW)) bus ();

    accum_window #(.IW(IW), .DW(DW), .NUM(NUM)) dut (
        .i_Sys_clk (clk),
        .i_Rst     (rst),
        .bus       (bus.slave)
    );

    // Model: the window is just the list of accepted samples.
    longint q[$];
    longint exp_sum;
    logic   exp_vld;
    logic   exp_ovf;
    longint m_a;
    logic   m_o;

    function automatic longint wrapv(input longint v);
        longint r;
        r = v & (MODV - 1);
        if (r > MAXV) r = r - MODV;
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    initial begin
        exp_sum = 0;
        exp_vld = 1'b0;
        exp_ovf = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_sum = 0;
            exp_vld = 1'b0;
            exp_ovf = 1'b0;
        end else begin
            exp_vld = 1'b0;
            if (bus.i_Clr) q.delete();
            if (bus.i_Data_vld) q.push_back(longint'(bus.i_Data));
            if (q.size() == NUM) begin
                m_a = 0;
                m_o = 1'b0;
                foreach (q[i]) begin
                    m_a = m_a + q[i];
`ifdef ACC_SAT_EN
                    if (m_a > MAXV) begin m_a = MAXV; m_o = 1'b1; end
                    else if (m_a < MINV) begin m_a = MINV; m_o = 1'b1; end
`endif
                end
                exp_sum = wrapv(m_a);
                exp_ovf = m_o;
                exp_vld = 1'b1;
                pulses++;
                q.delete();
            end
        end
        #2;
        chk("sum_vld", longint'(bus.o_Sum_vld), longint'(exp_vld));
        chk("sum", longint'(bus.o_Sum), exp_sum);
        chk("cnt", longint'(bus.o_Cnt), longint'(q.size()));
        if (exp_vld) chk("ovf", longint'(bus.o_Ovf), longint'(exp_ovf));
    end

    task automatic drive(input logic v, input logic c, input longint d);
        @(negedge clk);
        bus.i_Data_vld = v;
        bus.i_Clr      = c;
        bus.i_Data     = d[IW-1:0];
    endtask

    task automatic expect_pulse(input string nm, input longint s, input logic ov);
        @(posedge clk);
        #3;
        chk({nm, "_vld"}, longint'(bus.o_Sum_vld), 1);
        chk({nm, "_sum"}, longint'(bus.o_Sum), s);
        chk({nm, "_ovf"}, longint'(bus.o_Ovf), longint'(ov));
        chk({nm, "_cnt"}, longint'(bus.o_Cnt), 0);
    endtask

    int p0;
    int r;

    initial begin
        rst            = 1'b1;
        bus.i_Data_vld = 1'b0;
        bus.i_Clr      = 1'b0;
        bus.i_Data     = '0;
        repeat (2) @(negedge clk);
        chk("rst_sum", longint'(bus.o_Sum), 0);
        chk("rst_vld", longint'(bus.o_Sum_vld), 0);
        chk("rst_cnt", longint'(bus.o_Cnt), 0);
        rst = 1'b0;

        // 1..4 back to back
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, longint'(i));
        expect_pulse("t1", 10, 1'b0);

        // -5 x4 with idle gaps, single pulse
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, -5);
            drive(1'b0, 1'b0, 0);
            drive(1'b0, 1'b0, 0);
        end
        chk("t2_sum", longint'(bus.o_Sum), -20);
        chk("t2_pulses", longint'(pulses - p0), 1);

        // clear with a valid sample starts a new window
        p0 = pulses;
        drive(1'b1, 1'b0, 7);
        drive(1'b1, 1'b0, 7);
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 2);
        drive(1'b1, 1'b0, 3);
        drive(1'b1, 1'b0, 4);
        expect_pulse("t3", 10, 1'b0);
        chk("t3_pulses", longint'(pulses - p0), 1);

        // reset mid-window drops the partial sum
        drive(1'b1, 1'b0, 9);
        drive(1'b1, 1'b0, 9);
        drive(1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_sum", longint'(bus.o_Sum), 0);
        chk("t4_rst_cnt", longint'(bus.o_Cnt), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1);
        expect_pulse("t4", 4, 1'b0);

        // full-scale samples exceed DW, then a clean window
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32767);
`ifdef ACC_SAT_EN
        expect_pulse("t5", 65535, 1'b1);
`else
        expect_pulse("t5", -4, 1'b0);
`endif
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1);
        expect_pulse("t5b", 4, 1'b0);

        // back-to-back windows with no gap
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, longint'(i));
        expect_pulse("t6a", 10, 1'b0);
        for (int i = 5; i <= 8; i++) drive(1'b1, 1'b0, longint'(i));
        expect_pulse("t6b", 26, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst            = ($urandom_range(0, 499) == 0);
            bus.i_Data_vld = ($urandom_range(0, 3) != 0);
            bus.i_Clr      = ($urandom_range(0, 29) == 0);
            r = int'($urandom_range(0, 3));
            case (r)
                0:       bus.i_Data = 16'sh7FFF;
                1:       bus.i_Data = 16'sh8000;
                2:       bus.i_Data = IW'($urandom_range(0, 15)) - IW'(8);
                default: bus.i_Data = IW'($urandom);
            endcase
        end
        @(negedge clk);
        rst            = 1'b0;
        bus.i_Data_vld = 1'b0;
        bus.i_Clr      = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
